// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
//   Bus connection between the memory-access stage (master) and the memory
//   bus (slave). Request, grant, address strobe and ready are active-low.
//
//   bus_rd_data  slave -> master  32  read data, valid while bus_rdy_ is low
//   bus_rdy_     slave -> master   1  ready, ends the access (active-low)
//   bus_grnt_    slave -> master   1  grant (active-low)
//   bus_req_     master -> slave   1  request (active-low)
//   bus_as_      master -> slave   1  address strobe (active-low)
//   bus_addr     master -> slave  30  word address
//   bus_rw       master -> slave   1  READ=1, WRITE=0
//   bus_wr_data  master -> slave  32  write data
// -----------------------------------------------------------------------------
interface mem_stage_if;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;
  logic        bus_grnt_;
  logic        bus_req_;
  logic        bus_as_;
  logic [29:0] bus_addr;
  logic        bus_rw;
  logic [31:0] bus_wr_data;

  modport master (
    input  bus_rd_data, bus_rdy_, bus_grnt_,
    output bus_req_, bus_as_, bus_addr, bus_rw, bus_wr_data
  );

  modport slave (
    output bus_rd_data, bus_rdy_, bus_grnt_,
    input  bus_req_, bus_as_, bus_addr, bus_rw, bus_wr_data
  );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the five-stage pipeline. Performs word loads and
//   stores over a request/grant/ready bus, flags misaligned accesses, and
//   registers the result into the MEM/WB pipeline register.
//
//   clk, reset        clock (rising edge); asynchronous active-low reset
//   stall, flush      pipeline control: stall holds, flush clears MEM register
//   ex_*              EX/MEM pipeline register contents
//   bus               mem_stage_if master modport
//   busy              stage is waiting on the bus (controller stalls on it)
//   mem_*             MEM/WB pipeline register
// -----------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] ex_pc,
  input  logic        ex_en,
  input  logic        ex_br_flag,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [1:0]  ex_ctrl_op,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_we_,
  input  logic [2:0]  ex_exp_code,
  input  logic [31:0] ex_out,
  mem_stage_if.master bus,
  output logic        busy,
  output logic [29:0] mem_pc,
  output logic        mem_en,
  output logic        mem_br_flag,
  output logic [1:0]  mem_ctrl_op,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_we_,
  output logic [2:0]  mem_exp_code,
  output logic [31:0] mem_out
);

  localparam logic [1:0] OP_NOP         = 2'd0;
  localparam logic [1:0] OP_LDW         = 2'd1;
  localparam logic [1:0] OP_STW         = 2'd2;
  localparam logic [1:0] CTRL_OP_NOP    = 2'd0;
  localparam logic [2:0] EXP_NO_EXP     = 3'd0;
  localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;
  localparam logic       BUS_READ       = 1'b1;
  localparam logic       BUS_WRITE      = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACCESS,
    ST_STALL
  } state_e;

  typedef struct packed {
    logic [29:0] pc;
    logic        en;
    logic        br_flag;
    logic [1:0]  ctrl_op;
    logic [4:0]  dst_addr;
    logic        gpr_we_;
    logic [2:0]  exp_code;
    logic [31:0] out;
  } mem_reg_t;

  localparam mem_reg_t MEM_RESET = '{pc: '0, en: 1'b0, br_flag: 1'b0,
                                     ctrl_op: CTRL_OP_NOP, dst_addr: '0,
                                     gpr_we_: 1'b1, exp_code: EXP_NO_EXP,
                                     out: '0};

  state_e      state_q;
  logic [31:0] rd_buf_q;
  mem_reg_t    mem_q;
  mem_reg_t    mem_d;
  logic [31:0] load_data;
  logic [31:0] mem_out_d;
  logic        miss_align;
  logic        access;

  assign miss_align = ex_en && (ex_mem_op != OP_NOP) && (ex_out[1:0] != 2'b00);
  assign access     = ex_en && (ex_mem_op != OP_NOP) && !miss_align &&
                      (ex_exp_code == EXP_NO_EXP) && !flush;

  // Gated by reset so the controller never sees a stall request while the
  // stage is held in reset, whatever the EX inputs look like.
  assign busy = reset && (((state_q == ST_IDLE) && access) ||
                          (state_q == ST_REQ) ||
                          ((state_q == ST_ACCESS) && bus.bus_rdy_));

  // Bus FSM. Once a request is issued it runs to bus_rdy_ regardless of
  // flush; the controller keeps the EX inputs stable until then.
  // NOTE: sequential state uses non-blocking assignments with an async
  // active-low clear, so every flop sees pre-edge values and resets at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rd_buf_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE:   if (access) state_q <= ST_REQ;
        ST_REQ:    if (!bus.bus_grnt_) state_q <= ST_ACCESS;
        ST_ACCESS: begin
          if (!bus.bus_rdy_) begin
            rd_buf_q <= bus.bus_rd_data;
            state_q  <= stall ? ST_STALL : ST_IDLE;
          end
        end
        ST_STALL:  if (!stall) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus outputs decode from the registered state, so they fall back to idle
  // the instant reset clears the FSM.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.bus_req_     = 1'b1;
    bus.bus_as_      = 1'b1;
    bus.bus_addr     = '0;
    bus.bus_rw       = BUS_READ;
    bus.bus_wr_data  = '0;
    case (state_q)
      ST_REQ: bus.bus_req_ = 1'b0;
      ST_ACCESS: begin
        bus.bus_req_    = 1'b0;
        bus.bus_as_     = 1'b0;
        bus.bus_addr    = ex_out[31:2];
        bus.bus_rw      = (ex_mem_op == OP_STW) ? BUS_WRITE : BUS_READ;
        bus.bus_wr_data = (ex_mem_op == OP_STW) ? ex_mem_wr_data : '0;
      end
      default: ;
    endcase
  end

  // Live bus data on the ready cycle; the buffered copy once the FSM has
  // parked in STALL waiting for the pipeline to move.
  assign load_data = (state_q == ST_ACCESS) ? bus.bus_rd_data : rd_buf_q;

  always_comb begin
    case (ex_mem_op)
      OP_LDW:  mem_out_d = load_data;
      OP_STW:  mem_out_d = '0;
      default: mem_out_d = ex_out;
    endcase
  end

  always_comb begin
    mem_d = MEM_RESET;
    if (flush) begin
      mem_d = MEM_RESET;
    end else if (miss_align) begin
      mem_d = '{pc: ex_pc, en: ex_en, br_flag: ex_br_flag,
                ctrl_op: CTRL_OP_NOP, dst_addr: '0, gpr_we_: 1'b1,
                exp_code: EXP_MISS_ALIGN, out: '0};
    end else begin
      mem_d = '{pc: ex_pc, en: ex_en, br_flag: ex_br_flag,
                ctrl_op: ex_ctrl_op, dst_addr: ex_dst_addr,
                gpr_we_: ex_gpr_we_, exp_code: ex_exp_code, out: mem_out_d};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= MEM_RESET;
    end else if (!stall) begin
      mem_q <= mem_d;
    end
  end

  assign mem_pc       = mem_q.pc;
  assign mem_en       = mem_q.en;
  assign mem_br_flag  = mem_q.br_flag;
  assign mem_ctrl_op  = mem_q.ctrl_op;
  assign mem_dst_addr = mem_q.dst_addr;
  assign mem_gpr_we_  = mem_q.gpr_we_;
  assign mem_exp_code = mem_q.exp_code;
  assign mem_out      = mem_q.out;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It consumes the EX pipeline-register outputs, performs word loads and stores through a request/grant/ready bus handshake, and detects misaligned accesses. It registers results into the MEM/WB pipeline register feeding writeback and the exception controller, and raises `busy` so the pipeline controller stalls the pipeline during bus waits.

## Interface
- No parameters; widths fixed: word address 30, data 32, register address 5.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `stall`, `flush` in 1 each: from the pipeline controller; `stall` holds, `flush` clears the MEM register.
- `ex_pc` in 30, `ex_en` in 1, `ex_br_flag` in 1: pass-through.
- `ex_mem_op` in 2: NOP=0, LDW=1, STW=2.
- `ex_mem_wr_data` in 32: store data.
- `ex_ctrl_op` in 2, `ex_dst_addr` in 5, `ex_gpr_we_` in 1 (active-low): pass-through.
- `ex_exp_code` in 3, `ex_out` in 32: exception code; ALU result / byte address.
- `bus_rd_data` in 32, `bus_rdy_` in 1, `bus_grnt_` in 1: bus read data, ready (active-low), grant (active-low).
- `bus_req_` out 1, `bus_as_` out 1: bus request and address strobe (active-low).
- `bus_addr` out 30, `bus_rw` out 1, `bus_wr_data` out 32: word address, READ=1/WRITE=0, write data.
- `busy` out 1: stage is waiting on the bus.
- `mem_pc` out 30, `mem_en` out 1, `mem_br_flag` out 1, `mem_ctrl_op` out 2, `mem_dst_addr` out 5, `mem_gpr_we_` out 1, `mem_exp_code` out 3, `mem_out` out 32: MEM/WB pipeline register.

## Operation
- Exception codes: NO_EXP=0, EXT_INT=1, UNDEF_INSN=2, OVERFLOW=3, MISS_ALIGN=4, TRAP=5, PRV_VIO=6.
- `miss_align` = `ex_en` & `ex_mem_op`≠NOP & `ex_out[1:0]`≠0.
- `access` = `ex_en` & `ex_mem_op`≠NOP & !`miss_align` & `ex_exp_code`==NO_EXP & !`flush`.
- Bus FSM, 4 states:
  - IDLE: `access` -> REQ.
  - REQ: `bus_req_`=0; `bus_grnt_`==0 -> ACCESS.
  - ACCESS: `bus_req_`=0, `bus_as_`=0, `bus_addr`=`ex_out[31:2]`, `bus_rw`=READ for LDW and WRITE for STW, `bus_wr_data`=`ex_mem_wr_data` for STW. On `bus_rdy_`==0, capture `bus_rd_data` into `rd_buf`, then go to STALL if `stall`, otherwise IDLE.
  - STALL: bus idle; `stall`==0 -> IDLE.
- Outside ACCESS, bus outputs idle: `bus_req_`=1 except in REQ, `bus_as_`=1, `bus_addr`=0, `bus_rw`=READ, `bus_wr_data`=0.
- `busy` is combinational: (IDLE & `access`) | REQ | (ACCESS & `bus_rdy_`). It is 0 in STALL.
- Load data is `bus_rd_data` in the ACCESS/ready cycle and `rd_buf` in STALL.
- `mem_out` source: LDW -> load data; STW -> 0; NOP -> `ex_out`.
- MEM register update priority:
  1. `reset`: clear to reset values.
  2. `stall`: hold.
  3. `flush`: clear to reset values.
  4. `miss_align`: pass pc/en/br_flag; `mem_ctrl_op`=NOP, `mem_dst_addr`=0, `mem_gpr_we_`=1, `mem_exp_code`=MISS_ALIGN, `mem_out`=0.
  5. Otherwise: pass all ex fields and `mem_out`.
- An incoming `ex_exp_code`≠NO_EXP passes through, and no bus access is made.
- `flush` never aborts a started transaction. REQ/ACCESS run to `bus_rdy_`; the upstream EX inputs are held stable by the controller meanwhile.

## Timing
- Reset values:
  - MEM register: `mem_pc`=0, `mem_en`=0, `mem_br_flag`=0, `mem_ctrl_op`=0, `mem_dst_addr`=0, `mem_gpr_we_`=1, `mem_exp_code`=0, `mem_out`=0.
  - FSM in IDLE; `busy`=0; bus outputs idle.
- Minimum access with grant and ready immediate: cycle 0 IDLE (`busy`=1), cycle 1 REQ, cycle 2 ACCESS with `bus_rdy_`=0 (`busy`=0). The MEM register captures at the end of cycle 2 if `stall`=0. Load-to-`mem_out` latency is 3 edges.
- Each cycle of `bus_grnt_`=1 or `bus_rdy_`=1 adds one `busy` cycle.
- Non-memory instructions: 1-edge latency, `busy`=0.
- Reset asserted mid-transaction: FSM returns to IDLE immediately and bus outputs go idle asynchronously.

## Test plan
- Reset: drive `reset`=0 with random inputs -> all outputs at reset values, `bus_req_`=1, `busy`=0.
- Load: LDW, `ex_out`=0x0000_0104, grant and ready immediate, `bus_rd_data`=0xDEADBEEF -> `bus_addr`=0x41, `bus_rw`=1, `busy` high for 2 cycles, then `mem_out`=0xDEADBEEF with `mem_dst_addr` and `mem_gpr_we_` passed through.
- Store with waits: STW, `ex_out`=0x200, `ex_mem_wr_data`=0x1234_5678, grant after 2 cycles, ready after 3 -> `bus_rw`=0 and `bus_wr_data` held throughout ACCESS, `busy` high for 6 cycles, `mem_out`=0.
- Misalign: LDW with `ex_out`=0x103 -> no `bus_req_`, `mem_exp_code`=4, `mem_gpr_we_`=1, `mem_out`=0.
- Stall after ready: load completes while `stall`=1 for 2 cycles -> FSM in STALL, `busy`=0, MEM register held; on release `mem_out`=`rd_buf` value.
- Flush and pass-through: `flush`=1 during ACCESS -> bus completes normally, MEM register cleared. Then an ADD with `ex_out`=0x55 and `ex_exp_code`=3 -> `mem_out`=0x55, `mem_exp_code`=3, no bus activity.
